// File: rtl/uart_rx_irq_fifo_pkg.sv
// uart_rx_irq_fifo_pkg: I/O addresses, RX_STAT bit positions and shared helpers for the RX FIFO block.
package uart_rx_irq_fifo_pkg;
  localparam logic [13:0] RX_DATA   = 14'h3E90;
  localparam logic [13:0] RX_STAT   = 14'h3E91;
  localparam logic [13:0] RX_THRESH = 14'h3E92;
  localparam int STAT_EMPTY = 8;
  localparam int STAT_FULL  = 9;
  localparam int STAT_OVF   = 10;
  localparam int STAT_FLUSH = 11;
  typedef enum logic [1:0] {SEL_NONE, SEL_POP, SEL_REG} rd_sel_e;
  // Threshold 0 behaves as 1; anything above the FIFO depth saturates at the depth.
  function automatic logic [7:0] eff_thresh(input logic [7:0] t, input int depth);
    return (t == 8'd0) ? 8'd1 : (int'(t) > depth) ? 8'(depth) : t;
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: DEPTH x 8 storage with one write port and a registered read port.
module sync_fifo_mem
  import uart_rx_irq_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/uart_rx_irq_fifo.sv
// uart_rx_irq_fifo: UART RX byte FIFO on the chained I/O bus with a threshold interrupt pulse.
// Define UART_RX_TIMEOUT_EN to add the idle-timeout interrupt source.
module uart_rx_irq_fifo
  import uart_rx_irq_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  input  logic         dma_io_we,
  input  logic [15:2]  dma_io_wadr,
  input  logic [31:0]  dma_io_wdata,
  input  logic [15:2]  dma_io_radr,
  input  logic         dma_io_radr_en,
  input  logic [31:0]  dma_io_rdata_in,
  output logic [31:0]  dma_io_rdata,
  output logic         ext_uart_interrpt_1shot
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0] count_q, count_d, thresh_q, thresh_d, eff, mem_rdata;
  logic [31:0] reg_q, reg_d, stat;
  logic ovf_q, ovf_d, level_dly_q, full, empty, level, push, pop, flush, stat_wr, rd_hit, tmo_pulse;
  rd_sel_e sel_q, sel_d;
  logic unused_wdata;
  assign unused_wdata = ^{dma_io_wdata[31:12], dma_io_wdata[9:8]};
  always_comb begin
    full     = count_q == 8'(DEPTH);
    empty    = count_q == 8'd0;
    pop      = dma_io_radr_en && dma_io_radr == RX_DATA && !empty;
    stat_wr  = dma_io_we && dma_io_wadr == RX_STAT;
    flush    = stat_wr && dma_io_wdata[STAT_FLUSH];
    push     = rx_valid && (!full || pop) && !flush;
    eff      = eff_thresh(thresh_q, DEPTH);
    level    = count_q >= eff;
    stat     = {21'd0, ovf_q, full, empty, count_q};
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = flush ? 8'd0 : count_q + 8'(push) - 8'(pop);
    ovf_d    = (stat_wr && !dma_io_wdata[STAT_OVF]) ? 1'b0 : ovf_q || (rx_valid && full && !pop);
    thresh_d = (dma_io_we && dma_io_wadr == RX_THRESH) ? dma_io_wdata[7:0] : thresh_q;
    rd_hit   = dma_io_radr_en && (dma_io_radr == RX_DATA || dma_io_radr == RX_STAT || dma_io_radr == RX_THRESH);
    sel_d    = pop ? SEL_POP : rd_hit ? SEL_REG : SEL_NONE;
    reg_d    = (dma_io_radr == RX_STAT) ? stat : (dma_io_radr == RX_THRESH) ? {24'd0, thresh_q} : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 8'd0;
      ovf_q       <= 1'b0;
      thresh_q    <= 8'd1;
      level_dly_q <= 1'b0;
      sel_q       <= SEL_NONE;
      reg_q       <= 32'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      thresh_q    <= thresh_d;
      level_dly_q <= level;
      sel_q       <= sel_d;
      reg_q       <= reg_d;
    end
  end
  sync_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );
`ifdef UART_RX_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic fired_q;
  // Idle count runs only while some bytes wait below threshold; it saturates at TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q   <= 16'd0;
      fired_q <= 1'b0;
    end else begin
      tmo_q   <= (!empty && count_q < eff && !push && !pop && !flush) ? ((tmo_q == 16'(TIMEOUT)) ? tmo_q : tmo_q + 16'd1) : 16'd0;
      fired_q <= (push || pop) ? 1'b0 : fired_q || tmo_pulse;
    end
  end
  assign tmo_pulse = tmo_q == 16'(TIMEOUT) && !fired_q;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT != 0;
  assign tmo_pulse = 1'b0;
`endif
  assign dma_io_rdata = (rst || sel_q == SEL_NONE) ? dma_io_rdata_in : (sel_q == SEL_POP) ? {23'd0, 1'b1, mem_rdata} : reg_q;
  assign ext_uart_interrpt_1shot = !rst && ((level && !level_dly_q) || tmo_pulse);
endmodule

// File: tb/tb_uart_rx_irq_fifo.sv
// tb_uart_rx_irq_fifo: scoreboard bench for the RX FIFO, I/O register map and interrupt pulse.
module tb_uart_rx_irq_fifo;
  import uart_rx_irq_fifo_pkg::*;
  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, dma_io_we = 1'b0, dma_io_radr_en = 1'b0, irq;
  logic [7:0] rx_data = 8'd0;
  logic [13:0] dma_io_wadr = 14'd0, dma_io_radr = 14'd0;
  logic [31:0] dma_io_wdata = 32'd0, dma_io_rdata_in = 32'hA5A5_0000, dma_io_rdata, d;
  int checks = 0, failures = 0, cyc = 0, irq_cnt = 0, last_irq = -1, n0, c0;
  logic [7:0] sbq [$];
  logic m_ovf = 1'b0;

  uart_rx_irq_fifo dut (
    .clk                     (clk),
    .rst                     (rst),
    .rx_data                 (rx_data),
    .rx_valid                (rx_valid),
    .dma_io_we               (dma_io_we),
    .dma_io_wadr             (dma_io_wadr),
    .dma_io_wdata            (dma_io_wdata),
    .dma_io_radr             (dma_io_radr),
    .dma_io_radr_en          (dma_io_radr_en),
    .dma_io_rdata_in         (dma_io_rdata_in),
    .dma_io_rdata            (dma_io_rdata),
    .ext_uart_interrpt_1shot (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (irq) begin
    irq_cnt++;
    last_irq = cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    if (sbq.size() < 16) sbq.push_back(b);
    else m_ovf = 1'b1;
    tick;
    rx_valid = 1'b0;
  endtask

  task automatic rd(input logic [13:0] adr, output logic [31:0] v);
    dma_io_radr = adr;
    dma_io_radr_en = 1'b1;
    tick;
    dma_io_radr_en = 1'b0;
    v = dma_io_rdata;
  endtask

  task automatic wr(input logic [13:0] adr, input logic [31:0] v);
    dma_io_wadr = adr;
    dma_io_wdata = v;
    dma_io_we = 1'b1;
    tick;
    dma_io_we = 1'b0;
  endtask

  task automatic chk_data(input string tag);
    logic [31:0] exp, v;
    exp = 32'd0;
    if (sbq.size() != 0) exp = {23'd0, 1'b1, sbq.pop_front()};
    rd(RX_DATA, v);
    check(tag, v, exp);
  endtask

  task automatic chk_stat(input string tag);
    logic [31:0] exp, v;
    exp = {21'd0, m_ovf, sbq.size() == 16, sbq.size() == 0, 8'(sbq.size())};
    rd(RX_STAT, v);
    check(tag, v, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    dma_io_radr = RX_STAT;
    dma_io_radr_en = 1'b1;
    repeat (2) tick;
    check("rst_irq", irq, 0);
    check("rst_pass", dma_io_rdata, dma_io_rdata_in);
    rst = 1'b0;
    dma_io_radr_en = 1'b0;
    tick;
    check("post_rst_irq", irq, 0);
    check("post_rst_pass", dma_io_rdata, dma_io_rdata_in);
    chk_stat("rst_stat");
    rd(RX_THRESH, d);
    check("rst_thresh", d, 1);
    wr(RX_THRESH, 4);
    n0 = irq_cnt;
    for (int i = 0; i < 3; i++) push(8'h11 + 8'(i));
    check("thr_early", irq_cnt - n0, 0);
    push(8'h14);
    check("thr_pulse", irq, 1);
    tick;
    check("thr_single", irq, 0);
    check("thr_cnt", irq_cnt - n0, 1);
    for (int i = 0; i < 4; i++) chk_data("thr_data");
    chk_data("empty_data");
    chk_stat("empty_stat");
    for (int i = 0; i < 17; i++) push(8'h20 + 8'(i));
    rd(RX_STAT, d);
    check("ovf_stat", d, 32'h610);
    wr(RX_STAT, 32'h0);
    m_ovf = 1'b0;
    chk_stat("ovf_clr");
    rx_data = 8'h55;
    rx_valid = 1'b1;
    dma_io_radr = RX_DATA;
    dma_io_radr_en = 1'b1;
    tick;
    rx_valid = 1'b0;
    dma_io_radr_en = 1'b0;
    check("both_data", dma_io_rdata, {23'd0, 1'b1, sbq.pop_front()});
    sbq.push_back(8'h55);
    chk_stat("both_stat");
    while (sbq.size() != 0) chk_data("drain");
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
    chk_stat("cnt5_stat");
    wr(RX_STAT, 32'h800);
    sbq.delete();
    rd(RX_STAT, d);
    check("flush_stat", d, 32'h100);
    chk_data("flush_empty");
    wr(RX_THRESH, 0);
    rd(RX_THRESH, d);
    check("thr0_rd", d, 0);
    n0 = irq_cnt;
    push(8'h77);
    tick;
    check("thr0_pulse", irq_cnt - n0, 1);
    chk_data("thr0_data");
    wr(RX_THRESH, 200);
    n0 = irq_cnt;
    for (int i = 0; i < 15; i++) push(8'h80 + 8'(i));
    tick;
    check("clamp_none", irq_cnt - n0, 0);
    push(8'h8F);
    tick;
    check("clamp_pulse", irq_cnt - n0, 1);
    while (sbq.size() != 0) chk_data("clamp_drain");
    wr(RX_THRESH, 8);
    for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
    n0 = irq_cnt;
    rst = 1'b1;
    tick;
    check("rst_mid_pass", dma_io_rdata, dma_io_rdata_in);
    rst = 1'b0;
    sbq.delete();
    m_ovf = 1'b0;
    tick;
    check("rst_mid_irq", irq_cnt - n0, 0);
    rd(RX_STAT, d);
    check("rst_mid_stat", d, 32'h100);
    rd(RX_THRESH, d);
    check("rst_mid_thresh", d, 1);
    wr(RX_THRESH, 8);
    n0 = irq_cnt;
    push(8'h99);
    c0 = cyc;
    repeat (1100) tick;
`ifdef UART_RX_TIMEOUT_EN
    check("tmo_cnt", irq_cnt - n0, 1);
    check("tmo_cyc", last_irq - c0, 1024);
`else
    check("tmo_none", irq_cnt - n0, 0);
`endif
    chk_data("tmo_data");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_irq_fifo.md
UART_RX_IRQ_FIFO -- requirements
Module: uart_rx_irq_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 2..128).
REQ-002 SHALL have parameter TIMEOUT, default 1024, idle cycles before the timeout interrupt (2..65535).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_data  input  8  received byte from UART receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 SHALL have ports dma_io_we (input, 1), dma_io_wadr (input, [15:2]), dma_io_wdata (input, 32), dma_io_radr (input, [15:2]), dma_io_radr_en (input, 1), which form the I/O bus write/read request.
REQ-008 SHALL have port dma_io_rdata_in  input  32  read data from the previous block in the read chain.
REQ-009 SHALL have port dma_io_rdata  output  32  chained read data.
REQ-010 SHALL have port ext_uart_interrpt_1shot  output  1  one-cycle RX interrupt pulse to the interrupter.

Function
REQ-011 SHALL decode RX_DATA=14'h3E90, RX_STAT=14'h3E91, RX_THRESH=14'h3E92 on word address bits [15:2].
REQ-012 SHALL push rx_data when rx_valid=1 and the FIFO is not full; count increments by 1.
REQ-013 SHALL pop on dma_io_radr_en & radr==RX_DATA when not empty; dma_io_rdata next cycle = {23'd0, 1'b1, byte}.
REQ-014 SHALL return {32'd0} on RX_DATA read when empty, with no state change.
REQ-015 SHALL accept simultaneous push and pop in every state, full included; count is unchanged, and order is preserved.
REQ-016 SHALL drop the byte and set sticky overflow when push occurs while full without a pop.
REQ-017 SHALL return RX_STAT as {21'd0, overflow, full, empty, count[7:0]} one cycle after the read request.
REQ-018 SHALL clear overflow on an RX_STAT write with wdata[10]=0, and flush the FIFO (count=0, pointers=0) on an RX_STAT write with wdata[11]=1; flush overrides a same-cycle push.
REQ-019 SHALL write thresh=wdata[7:0] on an RX_THRESH write, with a read returning {24'd0, thresh}; thresh 0 acts as 1, and values above DEPTH act as DEPTH.
REQ-020 SHALL register read selection: dma_io_rdata = own register if that block's read was issued the previous cycle, else dma_io_rdata_in.
REQ-021 SHALL compute level = (count >= effective thresh) from registered count and register level into level_dly.
REQ-022 SHALL assert ext_uart_interrpt_1shot = level & ~level_dly (exactly one cycle per rising crossing).
REQ-023 SHALL not re-pulse while the level stays high; a new pulse requires count to drop below thresh and then re-cross.
REQ-024 SHALL operate FIFO pointers modulo DEPTH, with count ranging 0..DEPTH.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear pointers, count, overflow, level_dly, the timeout counter, and the read-select flops, and set thresh=1.
REQ-026 SHALL hold ext_uart_interrpt_1shot=0 and dma_io_rdata=dma_io_rdata_in during and the cycle after reset.
REQ-027 SHALL discard FIFO contents on reset mid-operation, with no interrupt emitted.

Configuration
REQ-028 SHALL, with UART_RX_TIMEOUT_EN defined, count idle cycles while 0<count<thresh; the counter resets on push, pop, flush or empty.
REQ-029 SHALL, with UART_RX_TIMEOUT_EN, when the idle counter reaches TIMEOUT, OR a one-cycle pulse into ext_uart_interrpt_1shot, and not re-fire until the next push or pop.
REQ-030 SHALL, without UART_RX_TIMEOUT_EN, omit the counter entirely; the interrupt is threshold-only.

Structure
REQ-031 SHALL place the RX_DATA/RX_STAT/RX_THRESH address constants and RX_STAT bit positions in the shared io package.
REQ-032 SHALL instantiate one sub-module sync_fifo_mem (DEPTH x 8 storage, write port plus registered read port); control and interrupt logic stay in the top module.

Verification
REQ-033 SHALL cover: thresh=4, push 4 bytes 0x11..0x14 -> single pulse on the cycle after count reaches 4; RX_DATA reads return 0x111..0x114 in order.
REQ-034 SHALL cover: push 17 bytes into DEPTH=16 -> RX_STAT reads 0x610 (overflow, full, count 16); the 17th byte is lost.
REQ-035 SHALL cover: full FIFO, push and pop in the same cycle -> count stays 16, overflow stays 0, and the popped byte is the oldest.
REQ-036 SHALL cover: RX_DATA read on empty -> 0x00000000; RX_STAT write 0x800 while count=5 -> RX_STAT reads 0x100.
REQ-037 SHALL cover: with UART_RX_TIMEOUT_EN, TIMEOUT=1024, thresh=8, push 1 byte and idle -> one pulse 1024 cycles after the push; none without the macro.
REQ-038 SHALL cover: rst asserted with count=3 -> next RX_STAT read returns 0x100; no interrupt pulse.
